// File: rtl/fifo_pkg.sv
// Shared defaults and index types for the distributed-RAM FIFO controller.
// Build option FIFO_BYPASS_EN (see dist_mem_fifo_ctrl) does not change anything here.
package fifo_pkg;
    localparam int unsigned FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned FIFO_DATA_W     = 8;

    typedef logic [FIFO_DEPTH_LOG2-1:0] fifo_ptr_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   fifo_cnt_t;
endpackage

// File: rtl/fifo_out_stage.sv
// One-entry output register of the FIFO: loads from RAM (refill) or directly from the
// producer (bypass), and empties on a pop that brings no replacement.
module fifo_out_stage
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              refill,
    input  logic              bypass,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] mem_spo,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (refill) begin
            out_valid <= 1'b1;
            out_data  <= mem_spo;
        end else if (bypass) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dist_mem_fifo_ctrl.sv
// FIFO controller sequencing a single-port distributed RAM with valid/ready on both sides.
// Define FIFO_BYPASS_EN to let pushes into an empty queue skip the RAM.
module dist_mem_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int unsigned DATA_W     = FIFO_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_d,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_spo
);

    localparam logic [DEPTH_LOG2:0]   MemFull = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CntOne  = (DEPTH_LOG2 + 1)'(1);

    logic [DEPTH_LOG2-1:0] head_q, tail_q;
    logic [DEPTH_LOG2:0]   mem_cnt_q;
    logic                  active, slot_free, mem_empty, mem_full;
    logic                  refill, bypass, write;

    assign active    = rst_n && !flush;
    assign slot_free = !out_valid || out_ready;
    assign mem_empty = (mem_cnt_q == '0);
    assign mem_full  = (mem_cnt_q == MemFull);

    // Refill owns the single RAM port, so a concurrent push has to wait a cycle.
    assign refill = active && slot_free && !mem_empty;
`ifdef FIFO_BYPASS_EN
    assign bypass = active && slot_free && mem_empty && in_valid;
`else
    assign bypass = 1'b0;
`endif
    assign in_ready = active && !refill && (!mem_full || slot_free);
    assign write    = !refill && !bypass && in_valid && in_ready;

    assign mem_we = write;
    assign mem_d  = in_data;
    assign count  = mem_cnt_q + {{DEPTH_LOG2{1'b0}}, out_valid};

    always_comb begin
        mem_a = head_q;
        if (!rst_n) begin
            mem_a = '0;
        end else if (write) begin
            mem_a = tail_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_q    <= '0;
            tail_q    <= '0;
            mem_cnt_q <= '0;
        end else if (refill) begin
            head_q    <= head_q + PtrOne;
            mem_cnt_q <= mem_cnt_q - CntOne;
        end else if (write) begin
            tail_q    <= tail_q + PtrOne;
            mem_cnt_q <= mem_cnt_q + CntOne;
        end
    end

    fifo_out_stage #(
        .DATA_W(DATA_W)
    ) u_out_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .refill   (refill),
        .bypass   (bypass),
        .out_ready(out_ready),
        .mem_spo  (mem_spo),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data)
    );

endmodule

// File: doc/dist_mem_fifo_ctrl.md
# dist_mem_fifo_ctrl

FIFO controller that sequences the single-port 16×8 distributed RAM (`dist_mem_gen`: `a`, `d`, `we`, synchronous write, asynchronous `spo` read) as a first-in/first-out queue with valid/ready handshakes on both sides. It owns the head and tail pointers, the occupancy count and a one-entry output register. Each cycle it decides whether the shared memory port performs a write (push) or a read (refill of the output register). The RAM instance sits in the parent and connects through the `mem_*` ports.

## Interface
- `DEPTH_LOG2`, 4, memory address width; memory holds 2^DEPTH_LOG2 entries
- `DATA_W`, 8, entry width

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `flush`  in  1  synchronous clear of queue contents
- `in_valid`  in  1  producer has data
- `in_ready`  out  1  push accepted this cycle when `in_valid && in_ready`
- `in_data`  in  DATA_W  push data
- `out_valid`  out  1  output register holds the head entry
- `out_ready`  in  1  consumer takes data; pop when `out_valid && out_ready`
- `out_data`  out  DATA_W  head entry, registered
- `count`  out  DEPTH_LOG2+1  total entries held, memory plus output register
- `mem_a`  out  DEPTH_LOG2  RAM address
- `mem_d`  out  DATA_W  RAM write data, equal to `in_data`
- `mem_we`  out  1  RAM write enable
- `mem_spo`  in  DATA_W  RAM asynchronous read data

## Operation
- Internal state: `head` and `tail` (DEPTH_LOG2 bits, wrap modulo 2^DEPTH_LOG2), `mem_cnt` (0..2^DEPTH_LOG2), `out_valid`, `out_data`.
- `count = mem_cnt + out_valid`. Capacity is 2^DEPTH_LOG2 + 1.
- `slot_free = !out_valid || out_ready`. This is true when the output register is empty or is being popped this cycle.
- Port decision, evaluated every cycle in this priority order:
  1. `refill = slot_free && mem_cnt != 0`.
     - `mem_a = head`.
     - At the clock edge: `out_data <= mem_spo`, `out_valid <= 1`, `head++`, `mem_cnt--`.
  2. `bypass = slot_free && mem_cnt == 0 && in_valid`.
     - No memory access.
     - At the clock edge: `out_data <= in_data`, `out_valid <= 1`.
  3. `write = !refill && !bypass && in_valid && in_ready`.
     - `mem_a = tail`, `mem_we = 1`.
     - At the clock edge: `tail++`, `mem_cnt++`.
  4. Pop with no refill and no bypass: `out_valid <= 0`.
- `in_ready = !refill && (mem_cnt != 2^DEPTH_LOG2 || slot_free)`.
  - It depends combinationally on `out_ready`.
  - While `refill` is active, push waits. The memory has one port, so refill wins.
- `mem_a = head` whenever no write is active. `mem_we` is asserted only for `write`.
- Full: `mem_cnt` is at maximum and `out_valid` is high with no pop. Then `in_ready = 0` and no memory write occurs.
- Empty: `count = 0`, so `out_valid = 0`. The first push takes the bypass path.
- Wrap-around: `head` and `tail` roll from 2^DEPTH_LOG2−1 to 0 with no special casing. `mem_cnt` distinguishes full from empty.
- `flush = 1`:
  - At the edge: `head`, `tail` and `mem_cnt` become 0 and `out_valid` becomes 0.
  - `in_ready = 0` and `mem_we = 0` that cycle; any push or pop is ignored.
  - `flush` has priority over everything except reset.

## Timing
- Reset (`rst_n = 0` at an edge): `head = tail = mem_cnt = 0`, `out_valid = 0`, `out_data = 0`, `count = 0`.
  - While `rst_n = 0`: `in_ready = 0`, `mem_we = 0`, `mem_a = 0`.
  - Reset mid-operation discards all contents. RAM contents are left stale and unreadable.
- Bypass latency: a push into an empty FIFO shows as `out_valid = 1` in the cycle after acceptance.
- Refill: reads `mem_spo` in the same cycle the slot frees. With `out_ready` held at 1 and the memory non-empty, one entry is delivered per cycle.
- Push latency through memory: at least 1 write cycle plus 1 refill cycle.
- Simultaneous push and pop with the memory non-empty: the pop triggers a refill and the push stalls one cycle.
- Simultaneous push and pop with the memory empty: bypass. The push data replaces the popped entry in the same edge.

## Configuration
- `FIFO_BYPASS_EN`
  - Defined: the bypass path exists as described above.
  - Undefined: `bypass` is constant 0. Every push goes through memory, and a push into an empty FIFO raises `out_valid` two cycles after acceptance.
  - `count` semantics and capacity are identical in both builds.

## Structure
- Package `fifo_pkg`:
  - `FIFO_DEPTH_LOG2` and `FIFO_DATA_W` defaults
  - `fifo_ptr_t` (DEPTH_LOG2 bits)
  - `fifo_cnt_t` (DEPTH_LOG2+1 bits)
- Natural sub-module: `fifo_out_stage`, which holds the output register, the `out_valid` flag and the refill/bypass load mux.
- Pointers, counters and the port decision stay in `dist_mem_fifo_ctrl`. The RAM is not instantiated inside.

## Test plan
All scenarios use DEPTH_LOG2 = 4, DATA_W = 8, and the real `dist_mem_gen` as the RAM model.

- Reset: `rst_n = 0` for 2 cycles with `in_valid = 1` → `in_ready = 0`, `mem_we = 0`, `out_valid = 0`, `count = 0`; after release `in_ready = 1`.
- Bypass: push 0x05 into an empty FIFO with `out_ready = 0` → next cycle `out_valid = 1`, `out_data = 0x05`, `count = 1`, `mem_we` never high. With `FIFO_BYPASS_EN` undefined → `out_valid` rises one cycle later and `mem_we` pulses at `mem_a = 0`.
- Fill: push 0x00..0x10 with `out_ready = 0` → 17 pushes accepted, `mem_we` at addresses 0..15, then `in_ready = 0` and `count = 17`; an 18th value of 0xAA is held and not written.
- Drain and wrap: from full, `out_ready = 1`, `in_valid = 0` → `out_data` reads 0x00..0x10 on consecutive cycles, then `out_valid = 0`. Refill 20 more values → `tail` wraps and the order is preserved.
- Contention: 3 entries in memory, `out_ready = 1`, `in_valid = 1` with 0x77 → `in_ready = 0` for 3 refill cycles, then 0x77 bypasses and `out_data = 0x77` after the third stored entry.
- Flush: `count = 9`, `flush = 1` with `in_valid = 1` → next cycle `count = 0`, `out_valid = 0`, no write that cycle; the next push of 0x3C appears as the head.
